// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types and constants for the fp32 rounding datapath.
//   rm_e     - IEEE 754 rounding-mode encoding as carried on the rm port
//   fp32n_t  - normalised word from the normaliser: sign, exp, sig[25:0]
//              (sig[25]=hidden, sig[24:2]=fraction, sig[1]=guard, sig[0]=sticky)
//   fp32r_t  - packed IEEE single result: sign, exp, frac
//   FP32_INF, FP32_MAXF - magnitudes (sign excluded) of infinity / max finite
//   FP32_QNAN           - canonical quiet NaN; its fraction MSB is the quiet bit
package fp32_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [25:0] sig;
    } fp32n_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32r_t;

    localparam logic [30:0] FP32_INF  = 31'h7F80_0000;
    localparam logic [30:0] FP32_MAXF = 31'h7F7F_FFFF;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // Encodings 5-7 are reserved and behave as round-to-nearest-even.
    function automatic rm_e decode_rm(input logic [2:0] raw);
        case (raw)
            3'd1:    return RM_RTZ;
            3'd2:    return RM_RDN;
            3'd3:    return RM_RUP;
            3'd4:    return RM_RMM;
            default: return RM_RNE;
        endcase
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// fp_round_decide: combinational round-up decision, independent of word width
// so the fp64 rounder can reuse it.
//   i_sign    - sign of the value being rounded
//   i_lsb     - least significant kept fraction bit
//   i_g, i_s  - guard and sticky bits
//   i_rm      - decoded rounding mode
//   o_roundup - 1 when one ulp must be added to the kept magnitude
module fp_round_decide
    import fp32_pkg::*;
(
    input  logic i_sign,
    input  logic i_lsb,
    input  logic i_g,
    input  logic i_s,
    input  rm_e  i_rm,
    output logic o_roundup
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        o_roundup = 1'b0;
        case (i_rm)
            RM_RNE:  o_roundup = i_g & (i_s | i_lsb);
            RM_RTZ:  o_roundup = 1'b0;
            RM_RDN:  o_roundup = i_sign & (i_g | i_s);
            RM_RUP:  o_roundup = ~i_sign & (i_g | i_s);
            RM_RMM:  o_roundup = i_g;
            default: o_roundup = i_g & (i_s | i_lsb);
        endcase
    end

endmodule

// File: rtl/fp_round32_l2.sv
// fp_round32_l2: two-stage IEEE single rounding stage fed by the fp32
// normaliser. Stage 1 decides the round-up bit; stage 2 adds it, resolves
// overflow per mode, quiets NaNs and forms the exception flags.
//   clk, rst_n   - clock, asynchronous active-low reset
//   ce           - clock enable; every register holds while low
//   vld_i, i     - input word valid / normalised word (fp32n_t)
//   rm           - rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, else RNE)
//   under_i      - normaliser underflow (value is tiny before rounding)
//   inexact_i    - normaliser already discarded nonzero bits
//   vld_o, o     - result valid / packed IEEE single result
//   inexact_o, overflow_o, underflow_o - exception flags of the result
module fp_round32_l2
    import fp32_pkg::*;
#(
    parameter int LAT        = 2,
    parameter bit QNAN_FORCE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        vld_i,
    input  fp32n_t      i,
    input  logic [2:0]  rm,
    input  logic        under_i,
    input  logic        inexact_i,
    output logic        vld_o,
    output logic [31:0] o,
    output logic        inexact_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    generate
        if (LAT != 2) begin : g_bad_lat
            $error("fp_round32_l2: LAT must be 2");
        end
    endgenerate

    // ---------------- stage 1: round decision ----------------
    rm_e  w_rm;
    logic w_roundup;

    assign w_rm = decode_rm(rm);

    fp_round_decide u_decide (
        .i_sign    (i.sign),
        .i_lsb     (i.sig[2]),
        .i_g       (i.sig[1]),
        .i_s       (i.sig[0]),
        .i_rm      (w_rm),
        .o_roundup (w_roundup)
    );

    logic        r1_vld;
    logic        r1_sign;
    logic [7:0]  r1_exp;
    logic [22:0] r1_frac;
    logic        r1_special;
    logic        r1_zero;
    logic        r1_roundup;
    logic        r1_rinex;
    rm_e         r1_rm;
    logic        r1_under;
    logic        r1_inexact;

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // Data registers load only for valid words, so bubbles leave the last
    // values in place; only the valid bit tracks bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld     <= 1'b0;
            r1_sign    <= 1'b0;
            r1_exp     <= 8'h00;
            r1_frac    <= 23'h0;
            r1_special <= 1'b0;
            r1_zero    <= 1'b0;
            r1_roundup <= 1'b0;
            r1_rinex   <= 1'b0;
            r1_rm      <= RM_RNE;
            r1_under   <= 1'b0;
            r1_inexact <= 1'b0;
        end else if (ce) begin
            r1_vld <= vld_i;
            if (vld_i) begin
                r1_sign    <= i.sign;
                r1_exp     <= i.exp;
                r1_frac    <= i.sig[24:2];
                r1_special <= (i.exp == 8'hFF);
                r1_zero    <= (i.exp == 8'h00) && (i.sig == 26'h0);
                r1_roundup <= w_roundup;
                r1_rinex   <= i.sig[1] | i.sig[0];
                r1_rm      <= w_rm;
                r1_under   <= under_i;
                r1_inexact <= inexact_i;
            end
        end
    end

    // ---------------- stage 2: increment and exceptions ----------------
    // Adding the round bit across {exp, frac} lets a fraction carry bump the
    // exponent naturally (denormal -> normal, 1.111.. -> 2.0).
    logic [30:0] w_sum;
    logic        w_carry;
    logic        w_ovf;
    logic [30:0] w_ovf_mag;
    logic [22:0] w_qbit;
    fp32r_t      w_res;
    logic        w_inexact;
    logic        w_overflow;
    logic        w_underflow;

    assign w_sum   = {r1_exp, r1_frac} + {30'd0, r1_roundup};
    assign w_carry = (w_sum[30:23] != r1_exp);
    assign w_ovf   = (w_sum[30:23] == 8'hFF) || ((r1_exp == 8'hFE) && w_carry);
    assign w_qbit  = (QNAN_FORCE && (r1_frac != 23'h0)) ? FP32_QNAN[22:0] : 23'h0;

    // Overflow saturates to infinity unless the mode rounds toward zero for
    // this sign, in which case the largest finite magnitude is returned.
    always_comb begin
        w_ovf_mag = FP32_INF;
        case (r1_rm)
            RM_RTZ:  w_ovf_mag = FP32_MAXF;
            RM_RDN:  w_ovf_mag = r1_sign ? FP32_INF : FP32_MAXF;
            RM_RUP:  w_ovf_mag = r1_sign ? FP32_MAXF : FP32_INF;
            default: w_ovf_mag = FP32_INF;
        endcase
    end

    always_comb begin
        w_res       = fp32r_t'({r1_sign, w_sum});
        w_inexact   = r1_inexact | r1_rinex;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        if (r1_special) begin
            w_res     = fp32r_t'({r1_sign, r1_exp, r1_frac | w_qbit});
            w_inexact = 1'b0;
        end else if (r1_zero) begin
            w_res     = fp32r_t'({r1_sign, 31'h0});
            w_inexact = 1'b0;
        end else begin
            if (w_ovf) begin
                w_res      = fp32r_t'({r1_sign, w_ovf_mag});
                w_inexact  = 1'b1;
                w_overflow = 1'b1;
            end
            // Tininess was judged by the normaliser, i.e. before rounding.
            w_underflow = r1_under & w_inexact;
        end
    end

    logic   r_vld_o;
    fp32r_t r_o;
    logic   r_inexact_o;
    logic   r_overflow_o;
    logic   r_underflow_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_o       <= 1'b0;
            r_o           <= '0;
            r_inexact_o   <= 1'b0;
            r_overflow_o  <= 1'b0;
            r_underflow_o <= 1'b0;
        end else if (ce) begin
            r_vld_o <= r1_vld;
            if (r1_vld) begin
                r_o           <= w_res;
                r_inexact_o   <= w_inexact;
                r_overflow_o  <= w_overflow;
                r_underflow_o <= w_underflow;
            end
        end
    end

    assign vld_o       = r_vld_o;
    assign o           = r_o;
    assign inexact_o   = r_inexact_o;
    assign overflow_o  = r_overflow_o;
    assign underflow_o = r_underflow_o;

endmodule

// File: tb/tb_fp_round32_l2.sv
// tb_fp_round32_l2: scoreboard bench for fp_round32_l2. Expected results are
// written as constants when each word is driven and compared, in order, when
// the DUT presents a fresh result.
module tb_fp_round32_l2;
    import fp32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        vld_i;
    fp32n_t      i;
    logic [2:0]  rm;
    logic        under_i;
    logic        inexact_i;
    logic        vld_o;
    logic [31:0] o;
    logic        inexact_o;
    logic        overflow_o;
    logic        underflow_o;

    fp_round32_l2 #(.LAT(2), .QNAN_FORCE(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .vld_i       (vld_i),
        .i           (i),
        .rm          (rm),
        .under_i     (under_i),
        .inexact_i   (inexact_i),
        .vld_o       (vld_o),
        .o           (o),
        .inexact_o   (inexact_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] o;
        logic        ix;
        logic        ov;
        logic        uf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic ce_at_edge = 1'b0;

    // A result is fresh only if the preceding edge was enabled.
    always @(posedge clk) ce_at_edge <= ce;

    always @(negedge clk) begin
        if (rst_n && ce_at_edge && vld_o) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got o=%h with empty scoreboard", o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({o, inexact_o, overflow_o, underflow_o} !== {e.o, e.ix, e.ov, e.uf}) begin
                    n_fail++;
                    $display("FAIL %s: got o=%h ix=%b ov=%b uf=%b, want o=%h ix=%b ov=%b uf=%b",
                             e.name, o, inexact_o, overflow_o, underflow_o, e.o, e.ix, e.ov, e.uf);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word; when push is set its expected result joins the queue.
    task automatic drive(input string nm, input logic sgn, input logic [7:0] e,
                         input logic [22:0] f, input logic g, input logic s,
                         input logic [2:0] m, input logic un, input logic ix_in,
                         input logic [31:0] eo, input logic eix, input logic eov,
                         input logic euf, input logic push);
        exp_t x;
        vld_i     = 1'b1;
        i         = {sgn, e, (e != 8'h00), f, g, s};
        rm        = m;
        under_i   = un;
        inexact_i = ix_in;
        if (push) begin
            x.name = nm; x.o = eo; x.ix = eix; x.ov = eov; x.uf = euf;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        vld_i = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) step();
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; vld_i = 1'b0; i = '0; rm = 3'd0;
        under_i = 1'b0; inexact_i = 1'b0;
        #3;
        n_checks++;
        if ({vld_o, o, inexact_o, overflow_o, underflow_o} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_state: got vld=%b o=%h ix=%b ov=%b uf=%b, want all 0",
                     vld_o, o, inexact_o, overflow_o, underflow_o);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_latency();
        drive("one_rne", 1'b0, 8'h7F, 23'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
              32'h3F80_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        vld_i = 1'b0;
        n_checks++;
        if (vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got vld_o=%b after 1 edge, want 0", vld_o);
        end
        step();
        n_checks++;
        if (vld_o !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_two: got vld_o=%b after 2 edges, want 1", vld_o);
        end
        step();
        n_checks++;
        if (vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble: got vld_o=%b after bubble, want 0", vld_o);
        end
        drain();
    endtask

    task automatic test_rounding();
        //    name          s     exp    frac        g     s     rm    un    ix_in  expected o     ix    ov    uf
        drive("rne_tie_odd", 1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h3F80_0002, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("rne_tie_even",1'b0, 8'h7F, 23'h000000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h3F80_0000, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("mant_carry",  1'b0, 8'h7F, 23'h7FFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("denorm_carry",1'b0, 8'h00, 23'h7FFFFF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0080_0000, 1'b1, 1'b0, 1'b1, 1'b1); step();
        vld_i = 1'b0; step();   // bubble mid-stream
        drive("rmm_tie",     1'b0, 8'h7F, 23'h000000, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 32'h3F80_0001, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("rtz_trunc",   1'b0, 8'h7F, 23'h000000, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h3F80_0000, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("rup_pos",     1'b0, 8'h7F, 23'h000000, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 32'h3F80_0001, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("rdn_neg",     1'b1, 8'h7F, 23'h000000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 32'hBF80_0001, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("rm6_as_rne",  1'b0, 8'h7F, 23'h000001, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 32'h3F80_0002, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("inex_passthr",1'b0, 8'h7F, 23'h000000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 32'h3F80_0000, 1'b1, 1'b0, 1'b1, 1'b1); step();
        drive("zero_neg",    1'b1, 8'h00, 23'h000000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drain();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rounding_drain: got %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_overflow_special();
        drive("ovf_rne",     1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b1); step();
        drive("ovf_rtz",     1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 32'h7F7F_FFFF, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("ovf_rdn_neg", 1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'hFF80_0000, 1'b1, 1'b1, 1'b0, 1'b1); step();
        drive("ovf_rup_pos", 1'b0, 8'hFE, 23'h7FFFFF, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 32'h7F80_0000, 1'b1, 1'b1, 1'b0, 1'b1); step();
        drive("rup_neg_max", 1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 32'hFF7F_FFFF, 1'b1, 1'b0, 1'b0, 1'b1); step();
        drive("inf_pass",    1'b0, 8'hFF, 23'h000000, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 32'h7F80_0000, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drive("nan_quiet",   1'b0, 8'hFF, 23'h000001, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 32'h7FC0_0001, 1'b0, 1'b0, 1'b0, 1'b1); step();
        drain();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_drain: got %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_ce_freeze();
        for (int k = 0; k < 6; k++) begin
            drive($sformatf("stream_%0d", k), 1'b0, 8'h7F, 23'(3 * k + 1), 1'b0, 1'b0,
                  3'd0, 1'b0, 1'b0, 32'h3F80_0000 | 32'(3 * k + 1), 1'b0, 1'b0, 1'b0, 1'b1);
            if (k == 3) begin
                ce = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    step();
                    n_checks++;
                    if (vld_o !== 1'b1 || o !== 32'h3F80_0004) begin
                        n_fail++;
                        $display("FAIL ce_freeze_%0d: got vld=%b o=%h, want vld=1 o=3f800004",
                                 c, vld_o, o);
                    end
                end
                ce = 1'b1;
            end
            step();
        end
        drain();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL ce_stream_drain: got %0d results outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset_inflight();
        int seen;
        seen = 0;
        drive("flight_a", 1'b0, 8'h80, 23'h000123, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0,
              32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive("flight_b", 1'b1, 8'h81, 23'h000456, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0,
              32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({vld_o, o, inexact_o, overflow_o, underflow_o} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_async: got vld=%b o=%h ix=%b ov=%b uf=%b, want all 0",
                     vld_o, o, inexact_o, overflow_o, underflow_o);
        end
        vld_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (vld_o) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_discard: got %0d results after release, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_rounding();
        test_overflow_special();
        test_ce_freeze();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
